top_002: RTL and testbench

//  Top level of the COA_CPU demo board. A multi-cycle datapath reads the 8-bit

---
 rtl/top_002.sv | 144 ++++++++++++++
 tb/tb_top_002.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/top_002.sv
// COA_CPU demo top: multi-cycle triangular-sum datapath (S = 1+..+Data) shown on a
// 4-digit multiplexed 7-segment display. Define LEADING_ZERO_BLANK_EN to blank leading zeros.
module top_002 #(
    parameter int SCAN_DIV = 16
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] Data,
    output logic [7:0] Dis,
    output logic [3:0] Cs
);

    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic [15:0] acc_reg, acc_next;
    logic [7:0]  cnt_reg, cnt_next;
    logic [15:0] res_reg, res_next;
    logic [7:0]  nsave_reg, nsave_next;

    logic [SCAN_W-1:0] scan_reg;
    logic [1:0]        idx_reg;
    logic [3:0]        cs_reg;
    logic [7:0]        dis_reg;
    logic [7:0]        digit_seg [4];

    function automatic logic [7:0] hex2seg(input logic [3:0] h);
        logic [7:0] s;
        case (h)
            4'h0: s = 8'hC0;
            4'h1: s = 8'hF9;
            4'h2: s = 8'hA4;
            4'h3: s = 8'hB0;
            4'h4: s = 8'h99;
            4'h5: s = 8'h92;
            4'h6: s = 8'h82;
            4'h7: s = 8'hF8;
            4'h8: s = 8'h80;
            4'h9: s = 8'h90;
            4'hA: s = 8'h88;
            4'hB: s = 8'h83;
            4'hC: s = 8'hC6;
            4'hD: s = 8'hA1;
            4'hE: s = 8'h86;
            default: s = 8'h8E;
        endcase
        return s;
    endfunction

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_reg <= ST_LOAD;
            acc_reg   <= 16'h0000;
            cnt_reg   <= 8'h00;
            res_reg   <= 16'h0000;
            nsave_reg <= 8'h00;
        end else begin
            state_reg <= state_next;
            acc_reg   <= acc_next;
            cnt_reg   <= cnt_next;
            res_reg   <= res_next;
            nsave_reg <= nsave_next;
        end
    end

    // res is written only when the count is exhausted, so the display never shows a partial sum.
    always_comb begin
        state_next = state_reg;
        acc_next   = acc_reg;
        cnt_next   = cnt_reg;
        res_next   = res_reg;
        nsave_next = nsave_reg;
        case (state_reg)
            ST_LOAD: begin
                cnt_next   = Data;
                nsave_next = Data;
                acc_next   = 16'h0000;
                state_next = ST_RUN;
            end
            ST_RUN: begin
                if (cnt_reg != 8'h00) begin
                    acc_next = acc_reg + {8'h00, cnt_reg};
                    cnt_next = cnt_reg - 8'd1;
                end else begin
                    res_next   = acc_reg;
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (Data != nsave_reg) begin
                    state_next = ST_LOAD;
                end
            end
            default: state_next = ST_LOAD;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_digit
`ifdef LEADING_ZERO_BLANK_EN
            if (gi == 0) begin : g_lsd
                assign digit_seg[gi] = hex2seg(res_reg[3:0]);
            end else begin : g_upper
                // Blank only when this digit and all more significant digits are zero.
                assign digit_seg[gi] = (res_reg[15:4*gi] == '0) ? 8'hFF
                                                                : hex2seg(res_reg[4*gi +: 4]);
            end
`else
            assign digit_seg[gi] = hex2seg(res_reg[4*gi +: 4]);
`endif
        end
    endgenerate

    // Cs and Dis come from the same index on the same edge so they can never disagree.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            scan_reg <= '0;
            idx_reg  <= 2'd0;
            cs_reg   <= 4'b1111;
            dis_reg  <= 8'hFF;
        end else begin
            if (scan_reg == SCAN_LAST) begin
                scan_reg <= '0;
                idx_reg  <= idx_reg + 2'd1;
            end else begin
                scan_reg <= scan_reg + SCAN_W'(1);
            end
            cs_reg  <= ~(4'b0001 << idx_reg);
            dis_reg <= digit_seg[idx_reg];
        end
    end

    assign Cs  = cs_reg;
    assign Dis = dis_reg;

endmodule

// File: tb/tb_top_002.sv
// Bench for top_002: directed scenarios then random operands, every cycle checked
// against an arithmetic model of result timing and display scan position.
module tb_top_002;

    localparam int SCAN_DIV = 16;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [7:0] Data = 8'd0;
    logic [7:0] Dis;
    logic [3:0] Cs;

    top_002 #(.SCAN_DIV(SCAN_DIV)) dut (
        .CLK (CLK),
        .RST (RST),
        .Data(Data),
        .Dis (Dis),
        .Cs  (Cs)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: edge count since release, phase (0 awaiting load, 1 computing, 2 idle),
    // latched operand, edge on which the result lands, and the shown result.
    int m_k;
    int m_phase;
    int m_n;
    int m_write_at;
    int m_res;

    function automatic int tri_sum(input int n);
        return n * (n + 1) / 2;
    endfunction

    function automatic logic [7:0] seg_of(input int h);
        logic [7:0] t [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
        return t[h];
    endfunction

    function automatic logic [7:0] shown(input int res, input int dig);
`ifdef LEADING_ZERO_BLANK_EN
        if (dig != 0 && (res >> (4 * dig)) == 0) return 8'hFF;
`endif
        return seg_of((res >> (4 * dig)) & 15);
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_k = 0;
        m_phase = 0;
        m_n = 0;
        m_write_at = 0;
        m_res = 0;
    endtask

    task automatic step();
        int dig;
        logic [3:0] ecs;
        logic [7:0] edis;
        @(posedge CLK);
        if (!RST) begin
            model_reset();
            ecs  = 4'b1111;
            edis = 8'hFF;
        end else begin
            m_k++;
            dig  = ((m_k - 1) / SCAN_DIV) % 4;
            ecs  = ~(4'b0001 << dig);
            edis = shown(m_res, dig);
            if (m_phase == 0) begin
                m_n = int'(Data);
                m_write_at = m_k + m_n + 1;
                m_phase = 1;
            end else if (m_phase == 1) begin
                if (m_k == m_write_at) begin
                    m_res = tri_sum(m_n);
                    m_phase = 2;
                end
            end else if (Data != m_n[7:0]) begin
                m_phase = 0;
            end
        end
        #1;
        check("cycle_cs", {12'h000, Cs}, {12'h000, ecs});
        check("cycle_dis", {8'h00, Dis}, {8'h00, edis});
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_idle(input int limit);
        int i;
        i = 0;
        while ((m_phase != 2 || Data != m_n[7:0]) && i < limit) begin
            step();
            i++;
        end
        check("wait_bound", {15'h0000, (i >= limit)}, 16'h0000);
    endtask

    task automatic wait_digit(input int d, input logic [7:0] exp, input string tag);
        int i;
        logic [3:0] sel;
        sel = ~(4'b0001 << d);
        step();
        i = 1;
        while (Cs !== sel && i < 4 * SCAN_DIV + 2) begin
            step();
            i++;
        end
        check({tag, "_cs"}, {12'h000, Cs}, {12'h000, sel});
        check(tag, {8'h00, Dis}, {8'h00, exp});
    endtask

    task automatic async_reset();
        #2 RST = 1'b0;
        model_reset();
        #1;
        check("async_rst_cs", {12'h000, Cs}, 16'h000F);
        check("async_rst_dis", {8'h00, Dis}, 16'h00FF);
    endtask

    initial begin
        logic [7:0] lz;
`ifdef LEADING_ZERO_BLANK_EN
        lz = 8'hFF;
`else
        lz = 8'hC0;
`endif
        model_reset();

        // Reset held with an operand present.
        Data = 8'd10;
        steps(100);
        $display("txn reset_hold: 100 cycles checked");

        RST = 1'b1;
        steps(12);
        wait_digit(0, 8'hF8, "n10_d0");
        wait_digit(1, 8'hB0, "n10_d1");
        wait_digit(2, lz, "n10_d2");
        wait_digit(3, lz, "n10_d3");
        $display("txn data=10 expect res=0037");

        Data = 8'd0;
        wait_idle(20);
        wait_digit(0, 8'hC0, "n0_d0");
        wait_digit(1, lz, "n0_d1");
        $display("txn data=0 expect res=0000");

        Data = 8'd255;
        wait_idle(300);
        wait_digit(0, 8'hC0, "n255_d0");
        wait_digit(1, 8'h80, "n255_d1");
        wait_digit(2, 8'h8E, "n255_d2");
        wait_digit(3, 8'hF8, "n255_d3");
        $display("txn data=255 expect res=7F80");

        // Recompute on operand change; old result stays visible meanwhile.
        Data = 8'd10;
        wait_idle(30);
        Data = 8'd3;
        steps(3);
        wait_idle(20);
        wait_digit(0, 8'h82, "n3_d0");
        wait_digit(1, lz, "n3_d1");
        $display("txn data 10->3 expect res=0006");

        // Reset pulled mid-computation, then a clean restart.
        Data = 8'd200;
        steps(50);
        async_reset();
        steps(3);
        RST = 1'b1;
        wait_idle(300);
        wait_digit(0, 8'h99, "n200_d0");
        wait_digit(1, 8'h80, "n200_d1");
        wait_digit(2, 8'h86, "n200_d2");
        wait_digit(3, 8'h99, "n200_d3");
        $display("txn data=200 with mid-run reset expect res=4E84");

        for (int t = 0; t < 25; t++) begin
            int nv;
            int mode;
            nv   = $urandom_range(0, 90);
            mode = $urandom_range(0, 7);
            Data = nv[7:0];
            if (mode == 0) begin
                steps($urandom_range(1, nv + 3));
                nv   = $urandom_range(0, 90);
                Data = nv[7:0];
            end else if (mode == 1) begin
                steps($urandom_range(1, nv + 3));
                async_reset();
                steps(2);
                RST = 1'b1;
            end
            wait_idle(400);
            steps(4 * SCAN_DIV);
            $display("txn random %0d: data=%0d mode=%0d expect res=%04h", t, nv, mode, m_res);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
